// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity mode codes and the parity helper.
// Used by the transmitter now and by the receiver later.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DEF_CLKS_PER_BIT = 868;

    // Parity bit that makes the total number of ones odd or even; unknown modes give 0.
    function automatic logic parity_bit(input logic [8:0] word, input int mode);
        logic p;
        p = ^word;
        case (mode)
            PAR_ODD:  parity_bit = ~p;
            PAR_EVEN: parity_bit = p;
            default:  parity_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side handshake of the UART transmitter: valid/data in, ready/busy back.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 valid;
    logic [DATA_BITS-1:0] data;
    logic                 ready;
    logic                 busy;

    modport master (output valid, output data, input ready, input busy);
    modport slave  (input valid, input data, output ready, output busy);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last clock of a bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic bit_end_o
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Wrap at the last count so the following bit starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign bit_end_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Every output is a flop, so the serial line never glitches.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_cfg_if.slave  tx,
    output logic          dout
);
    localparam logic       HAS_PAR  = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
    localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);
    localparam logic       LAST_STP = 1'(STOP_BITS - 1);

    uart_state_t          state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 dout_q, dout_d;
    logic                 ready_q, ready_d;
    logic                 accept_s;
    logic                 bit_end_s;

    assign accept_s = tx.valid && ready_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en_i     (state_q != ST_IDLE),
        .clr_i    (accept_s),
        .bit_end_o(bit_end_s)
    );

    // State and datapath registers; reset drops the frame and idles the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            stop_q  <= 1'b0;
            shift_q <= {DATA_BITS{1'b0}};
            par_q   <= 1'b0;
            dout_q  <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
        end
    end

    // Frame sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_START;
                else          state_d = state_q;
            end
            ST_START: begin
                if (bit_end_s) state_d = ST_DATA;
                else           state_d = state_q;
            end
            ST_DATA: begin
                if (bit_end_s && (idx_q == LAST_IDX)) state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                else                                  state_d = state_q;
            end
            ST_PARITY: begin
                if (bit_end_s) state_d = ST_STOP;
                else           state_d = state_q;
            end
            ST_STOP: begin
                if (bit_end_s && (stop_q == LAST_STP)) state_d = ST_IDLE;
                else                                   state_d = state_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, shift register and the next line level, all keyed on the next state.
    always_comb begin
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        dout_d  = 1'b1;
        ready_d = 1'b1;

        if (accept_s) begin
            idx_d   = 4'd0;
            stop_d  = 1'b0;
            shift_d = tx.data;
            par_d   = parity_bit(9'(tx.data), PARITY);
        end else if ((state_q == ST_DATA) && bit_end_s) begin
            idx_d   = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
        end else if ((state_q == ST_STOP) && bit_end_s) begin
            stop_d  = (stop_q == LAST_STP) ? 1'b0 : stop_q + 1'b1;
        end else begin
            idx_d   = idx_q;
        end

        case (state_d)
            ST_IDLE:   begin dout_d = 1'b1;       ready_d = 1'b1; end
            ST_START:  begin dout_d = 1'b0;       ready_d = 1'b0; end
            ST_DATA:   begin dout_d = shift_d[0]; ready_d = 1'b0; end
            ST_PARITY: begin dout_d = par_d;      ready_d = 1'b0; end
            ST_STOP:   begin dout_d = 1'b1;       ready_d = 1'b0; end
            default:   begin dout_d = 1'b1;       ready_d = 1'b1; end
        endcase
    end

    assign dout     = dout_q;
    assign tx.ready = ready_q;
    assign tx.busy  = ~ready_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: each accepted word pushes its per-clock line/ready pattern,
// and a negedge monitor pops one expectation per clock against the selected transmitter.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    typedef struct packed {
        logic dout;
        logic ready;
    } samp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_valid;
    logic [8:0] tb_data;
    int         sel;
    logic [4:0] dout_w;
    logic       cur_dout, cur_ready, cur_busy;
    samp_t      exp_q[$];
    int         total = 0;
    int         bad   = 0;

    // k: 0=8N1 1=8E1 2=8O1 3=7N2 (all 4 clk/bit), 4=8N1 at 868 clk/bit
    int cfg_cpb [5] = '{4, 4, 4, 4, 868};
    int cfg_bits[5] = '{8, 8, 8, 7, 8};
    int cfg_par [5] = '{0, 2, 1, 0, 0};
    int cfg_stop[5] = '{1, 1, 1, 2, 1};

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if4 ();

    assign if0.valid = tb_valid && (sel == 0);
    assign if1.valid = tb_valid && (sel == 1);
    assign if2.valid = tb_valid && (sel == 2);
    assign if3.valid = tb_valid && (sel == 3);
    assign if4.valid = tb_valid && (sel == 4);
    assign if0.data  = tb_data[7:0];
    assign if1.data  = tb_data[7:0];
    assign if2.data  = tb_data[7:0];
    assign if3.data  = tb_data[6:0];
    assign if4.data  = tb_data[7:0];

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_8n1 (.clk(clk), .rst(rst), .tx(if0), .dout(dout_w[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_8e1 (.clk(clk), .rst(rst), .tx(if1), .dout(dout_w[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        u_8o1 (.clk(clk), .rst(rst), .tx(if2), .dout(dout_w[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
        u_7n2 (.clk(clk), .rst(rst), .tx(if3), .dout(dout_w[3]));
    uart_tx_cfg #(.CLKS_PER_BIT(868), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_big (.clk(clk), .rst(rst), .tx(if4), .dout(dout_w[4]));

    always_comb begin
        cur_dout  = 1'b1;
        cur_ready = 1'b1;
        cur_busy  = 1'b0;
        case (sel)
            0: begin cur_dout = dout_w[0]; cur_ready = if0.ready; cur_busy = if0.busy; end
            1: begin cur_dout = dout_w[1]; cur_ready = if1.ready; cur_busy = if1.busy; end
            2: begin cur_dout = dout_w[2]; cur_ready = if2.ready; cur_busy = if2.busy; end
            3: begin cur_dout = dout_w[3]; cur_ready = if3.ready; cur_busy = if3.busy; end
            4: begin cur_dout = dout_w[4]; cur_ready = if4.ready; cur_busy = if4.busy; end
            default: begin cur_dout = 1'b1; cur_ready = 1'b1; cur_busy = 1'b0; end
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        samp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("dout",  32'(cur_dout),  32'(e.dout));
            check_val("ready", 32'(cur_ready), 32'(e.ready));
            check_val("busy",  32'(cur_busy),  32'(!e.ready));
        end
    end

    function automatic void push_bits(input int n, input logic b);
        for (int i = 0; i < n; i++) exp_q.push_back('{dout: b, ready: 1'b0});
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{dout: 1'b1, ready: 1'b1});
    endfunction

    function automatic void push_frame(input int k, input logic [8:0] w);
        push_bits(cfg_cpb[k], 1'b0);
        for (int i = 0; i < cfg_bits[k]; i++) push_bits(cfg_cpb[k], w[i]);
        if (cfg_par[k] == 1)      push_bits(cfg_cpb[k], ~^w);
        else if (cfg_par[k] == 2) push_bits(cfg_cpb[k], ^w);
        push_bits(cfg_cpb[k] * cfg_stop[k], 1'b1);
        push_idle(1);
    endfunction

    // Offer one word to idle transmitter k for a single cycle, then scramble data.
    task automatic send_word(input int k, input logic [8:0] w);
        @(negedge clk); #1;
        sel      = k;
        tb_valid = 1'b1;
        tb_data  = w;
        push_frame(k, w);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        tb_data  = ~w;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk); #2;
            n++;
        end
        check_val({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst      = 1'b1;
        tb_valid = 1'b0;
        tb_data  = 9'h000;
        sel      = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;

        // reset state of every configuration
        for (int k = 0; k < 5; k++) begin
            sel = k; #1;
            check_val("rst_dout",  32'(cur_dout),  32'd1);
            check_val("rst_ready", 32'(cur_ready), 32'd1);
            check_val("rst_busy",  32'(cur_busy),  32'd0);
        end

        // 8N1 A5
        send_word(0, 9'h0A5);
        drain("8n1_a5", 200);

        // 8E1 / 8O1 with 55
        send_word(1, 9'h055);
        drain("8e1_55", 200);
        send_word(2, 9'h055);
        drain("8o1_55", 200);

        // 7N2 7F, with a stray valid mid-frame that must be ignored
        send_word(3, 9'h07F);
        push_idle(80);
        repeat (10) @(negedge clk);
        #1; tb_valid = 1'b1; tb_data = 9'h000;
        @(negedge clk); #1; tb_valid = 1'b0;
        drain("7n2_7f", 300);

        // back-to-back with valid held high
        @(negedge clk); #1;
        sel      = 0;
        tb_valid = 1'b1;
        tb_data  = 9'h000;
        push_frame(0, 9'h000);
        @(posedge clk); #1;
        tb_data = 9'h0FF;
        push_frame(0, 9'h0FF);
        push_idle(10);
        repeat (41) @(posedge clk);
        #1; tb_valid = 1'b0;
        drain("b2b", 300);

        // reset in the middle of the data bits
        @(negedge clk); #1;
        sel      = 0;
        tb_valid = 1'b1;
        tb_data  = 9'h0C3;
        push_bits(4, 1'b0);
        push_bits(2, 1'b1);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        drain("pre_rst", 50);
        rst = 1'b1; #1;
        check_val("midrst_dout",  32'(cur_dout),  32'd1);
        check_val("midrst_ready", 32'(cur_ready), 32'd1);
        check_val("midrst_busy",  32'(cur_busy),  32'd0);
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        push_idle(60);
        drain("post_rst", 100);

        // full-rate divider
        send_word(4, 9'h041);
        drain("big_41", 9000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
